// File: rtl/rcpu_pkg.sv
// Shared types and constants for the multi-cycle R-type core.
// Holds the FSM state, ALU op encoding and the instruction decoder.
package rcpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLLV
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic    legal;
        logic    halt;
        alu_op_t op;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.legal = 1'b0;
        d.halt  = 1'b0;
        d.op    = ALU_ADD;
        if (ins == HALT_WORD) begin
            d.halt = 1'b1;
        end else if (ins[31:26] == OP_RTYPE) begin
            d.legal = 1'b1;
            case (ins[5:0])
                FUNCT_ADD:  d.op = ALU_ADD;
                FUNCT_SUB:  d.op = ALU_SUB;
                FUNCT_AND:  d.op = ALU_AND;
                FUNCT_OR:   d.op = ALU_OR;
                FUNCT_XOR:  d.op = ALU_XOR;
                FUNCT_NOR:  d.op = ALU_NOR;
                FUNCT_SLT:  d.op = ALU_SLT;
                FUNCT_SLLV: d.op = ALU_SLLV;
                default:    d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rcpu_alu.sv
// Combinational ALU: arithmetic with carry/overflow, logic ops,
// signed set-less-than and variable left shift.
module rcpu_alu
    import rcpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       op,
    output logic [DW-1:0] f,
    output logic          zf,
    output logic          of,
    output logic          cf
);

    localparam int SW = $clog2(DW);

    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        f  = '0;
        of = 1'b0;
        cf = 1'b0;
        case (op)
            ALU_ADD: begin
                f  = sum[DW-1:0];
                cf = sum[DW];
                of = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                // top bit of the widened difference is the borrow
                f  = diff[DW-1:0];
                cf = diff[DW];
                of = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            ALU_AND:  f = a & b;
            ALU_OR:   f = a | b;
            ALU_XOR:  f = a ^ b;
            ALU_NOR:  f = ~(a | b);
            ALU_SLT:  f = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLLV: f = b << a[SW-1:0];
        endcase
    end

    assign zf = (f == '0);

endmodule

// File: rtl/rcpu_multicycle.sv
// Multi-cycle R-type core: IDLE -> FETCH -> EXEC -> WB per step,
// with inline register file, flags, illegal/halt detection and retire count.
module rcpu_multicycle
    import rcpu_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          RF_AW    = 5,
    parameter int          IM_AW    = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_data,
    output logic [DW-1:0]    alu_f,
    output logic             fr_zf,
    output logic             fr_of,
    output logic             fr_cf,
    output logic             illegal,
    output logic             halted,
    output logic             busy,
    output logic [15:0]      retired
);

    localparam int PW = IM_AW + 2;
    localparam int NR = 1 << RF_AW;

    state_t           state;
    logic [PW-1:0]    pc;
    logic [DW-1:0]    rf [NR];

    logic [RF_AW-1:0] rs_idx;
    logic [RF_AW-1:0] rt_idx;
    logic [RF_AW-1:0] rd_idx;
    logic [DW-1:0]    rs_val;
    logic [DW-1:0]    rt_val;
    dec_t             dec;

    logic [DW-1:0]    f;
    logic             zf;
    logic             of;
    logic             cf;

    logic [DW-1:0]    x_f;
    logic             x_zf;
    logic             x_of;
    logic             x_cf;
    logic             x_legal;
    logic             x_halt;
    logic [RF_AW-1:0] x_rd;

    assign imem_addr = pc[PW-1:2];
    assign busy      = (state != S_IDLE);

    // ROM data is only valid in EXEC, so decode and operand reads use it directly
    assign rs_idx = imem_data[21 +: RF_AW];
    assign rt_idx = imem_data[16 +: RF_AW];
    assign rd_idx = imem_data[11 +: RF_AW];
    assign rs_val = (rs_idx == '0) ? '0 : rf[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : rf[rt_idx];
    assign dec    = decode(imem_data);

    rcpu_alu #(
        .DW(DW)
    ) u_alu (
        .a (rs_val),
        .b (rt_val),
        .op(dec.op),
        .f (f),
        .zf(zf),
        .of(of),
        .cf(cf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC[PW-1:0];
            for (int i = 0; i < NR; i++) rf[i] <= '0;
            alu_f   <= '0;
            fr_zf   <= 1'b0;
            fr_of   <= 1'b0;
            fr_cf   <= 1'b0;
            illegal <= 1'b0;
            halted  <= 1'b0;
            retired <= '0;
            x_f     <= '0;
            x_zf    <= 1'b0;
            x_of    <= 1'b0;
            x_cf    <= 1'b0;
            x_legal <= 1'b0;
            x_halt  <= 1'b0;
            x_rd    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (step && !halted) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    x_f     <= f;
                    x_zf    <= zf;
                    x_of    <= of;
                    x_cf    <= cf;
                    x_legal <= dec.legal;
                    x_halt  <= dec.halt;
                    x_rd    <= rd_idx;
                    state   <= S_WB;
                end
                S_WB: begin
                    if (x_halt) begin
                        halted <= 1'b1;
                    end else begin
                        pc      <= pc + PW'(4);
                        retired <= retired + 16'd1;
                        if (x_legal) begin
                            alu_f <= x_f;
                            fr_zf <= x_zf;
                            fr_of <= x_of;
                            fr_cf <= x_cf;
                            if (x_rd != '0) rf[x_rd] <= x_f;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcpu_multicycle.sv
// Self-checking bench: program table with scoreboard, plus hand-written
// step-timing, free-run, mid-instruction reset and halt sequences.
module tb_rcpu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] alu_f;
    logic        fr_zf;
    logic        fr_of;
    logic        fr_cf;
    logic        illegal;
    logic        halted;
    logic        busy;
    logic [15:0] retired;

    int total = 0;
    int bad = 0;

    logic [31:0] rom [64];

    typedef struct {
        logic [31:0] ins;
        logic [31:0] f;
        logic [2:0]  flg;
        logic        ill;
        logic        hlt;
        logic [15:0] ret;
        logic [5:0]  pa;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    vec_t sb [$];

    rcpu_multicycle dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .alu_f    (alu_f),
        .fr_zf    (fr_zf),
        .fr_of    (fr_of),
        .fr_cf    (fr_cf),
        .illegal  (illegal),
        .halted   (halted),
        .busy     (busy),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [31:0] rt(input logic [5:0] fn, input int rd,
                                       input int rs, input int rtn);
        logic [4:0] d;
        logic [4:0] s;
        logic [4:0] t;
        d = 5'(rd);
        s = 5'(rs);
        t = 5'(rtn);
        return {6'b000000, s, t, d, 5'b00000, fn};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] f,
                                input logic [2:0] flg, input logic ill,
                                input logic hlt);
        vec_t v;
        v.ins = ins;
        v.f   = f;
        v.flg = flg;
        v.ill = ill;
        v.hlt = hlt;
        v.ret = '0;
        v.pa  = '0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 8; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        check("done_in_budget", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SLT = 6'b101010;
    localparam logic [5:0] SLV = 6'b000100;

    initial begin
        vec_t e;
        vec_t g;

        // flg = {zf, of, cf}
        vecs[0]  = mk(rt(NOR, 1, 0, 0),   32'hFFFF_FFFF, 3'b000, 0, 0);
        vecs[1]  = mk(rt(SLT, 2, 1, 0),   32'h0000_0001, 3'b000, 0, 0);
        vecs[2]  = mk(rt(SLV, 9, 1, 2),   32'h8000_0000, 3'b000, 0, 0);
        vecs[3]  = mk(rt(NOR, 10, 9, 0),  32'h7FFF_FFFF, 3'b000, 0, 0);
        vecs[4]  = mk(rt(ADD, 3, 10, 2),  32'h8000_0000, 3'b010, 0, 0);
        vecs[5]  = mk(rt(OR, 11, 3, 0),   32'h8000_0000, 3'b000, 0, 0);
        vecs[6]  = mk(rt(ADD, 12, 2, 2),  32'h0000_0002, 3'b000, 0, 0);
        vecs[7]  = mk(rt(ADD, 12, 12, 12), 32'h0000_0004, 3'b000, 0, 0);
        vecs[8]  = mk(rt(ADD, 4, 12, 2),  32'h0000_0005, 3'b000, 0, 0);
        vecs[9]  = mk(rt(SUB, 0, 4, 4),   32'h0000_0000, 3'b100, 0, 0);
        vecs[10] = mk(rt(ADD, 0, 4, 4),   32'h0000_000A, 3'b000, 0, 0);
        vecs[11] = mk(rt(OR, 5, 0, 0),    32'h0000_0000, 3'b100, 0, 0);
        vecs[12] = mk(rt(ADD, 6, 1, 2),   32'h0000_0000, 3'b101, 0, 0);
        vecs[13] = mk(rt(SUB, 14, 0, 2),  32'hFFFF_FFFF, 3'b001, 0, 0);
        vecs[14] = mk(rt(SLT, 15, 1, 2),  32'h0000_0001, 3'b000, 0, 0);
        vecs[15] = mk(rt(SLT, 15, 2, 1),  32'h0000_0000, 3'b100, 0, 0);
        vecs[16] = mk(rt(ADD, 16, 12, 12), 32'h0000_0008, 3'b000, 0, 0);
        vecs[17] = mk(rt(ADD, 16, 16, 16), 32'h0000_0010, 3'b000, 0, 0);
        vecs[18] = mk(rt(ADD, 16, 16, 16), 32'h0000_0020, 3'b000, 0, 0);
        vecs[19] = mk(rt(ADD, 6, 16, 12), 32'h0000_0024, 3'b000, 0, 0);
        vecs[20] = mk(rt(SUB, 7, 12, 2),  32'h0000_0003, 3'b000, 0, 0);
        vecs[21] = mk(rt(SLV, 8, 6, 7),   32'h0000_0030, 3'b000, 0, 0);
        vecs[22] = mk(rt(SUB, 17, 9, 2),  32'h7FFF_FFFF, 3'b010, 0, 0);
        vecs[23] = mk(rt(XOR, 18, 1, 10), 32'h8000_0000, 3'b000, 0, 0);
        vecs[24] = mk(rt(AND, 18, 1, 10), 32'h7FFF_FFFF, 3'b000, 0, 0);
        vecs[25] = mk({6'b001000, 26'h0}, 32'h7FFF_FFFF, 3'b000, 1, 0);
        vecs[26] = mk(rt(6'h00, 18, 1, 1), 32'h7FFF_FFFF, 3'b000, 1, 0);
        vecs[27] = mk(rt(OR, 19, 18, 0),  32'h7FFF_FFFF, 3'b000, 1, 0);
        vecs[28] = mk(32'hFFFF_FFFF,      32'h7FFF_FFFF, 3'b000, 1, 1);

        for (int i = 0; i < 64; i++) rom[i] = (i < NV) ? vecs[i].ins : 32'h0;

        rst  = 1'b0;
        step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_alu_f", 64'(alu_f), 64'd0);
        check("rst_flags", 64'({fr_zf, fr_of, fr_cf}), 64'd0);
        check("rst_ill_halt", 64'({illegal, halted}), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            e     = vecs[i];
            e.ret = e.hlt ? 16'(i) : 16'(i + 1);
            e.pa  = e.hlt ? 6'(i) : 6'(i + 1);
            sb.push_back(e);
            pulse();
            check($sformatf("busy_start[%0d]", i), 64'(busy), 64'd1);
            wait_done();
            g = sb.pop_front();
            check($sformatf("alu_f[%0d]", i), 64'(alu_f), 64'(g.f));
            check($sformatf("flags[%0d]", i), 64'({fr_zf, fr_of, fr_cf}), 64'(g.flg));
            check($sformatf("ill_halt[%0d]", i), 64'({illegal, halted}), 64'({g.ill, g.hlt}));
            check($sformatf("retired[%0d]", i), 64'(retired), 64'(g.ret));
            check($sformatf("addr[%0d]", i), 64'(imem_addr), 64'(g.pa));
        end

        // halted core ignores further steps
        for (int j = 0; j < 2; j++) begin
            pulse();
            check("halt_busy", 64'(busy), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            check("halt_busy_late", 64'(busy), 64'd0);
            check("halt_retired", 64'(retired), 64'd28);
            check("halt_addr", 64'(imem_addr), 64'd28);
        end

        // reset clears halt; step pulse during EXEC is ignored
        do_reset();
        check("halt_cleared", 64'({halted, illegal}), 64'd0);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        check("pulse1_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        step = 1'b1;
        check("pulse2_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        step = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_ret1", 64'(retired), 64'd1);
        check("pulse_alu_f", 64'(alu_f), 64'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #1;
        check("pulse2_ignored_busy", 64'(busy), 64'd0);
        check("pulse2_ignored_ret", 64'(retired), 64'd1);

        // free-run: one retire every 4 cycles
        do_reset();
        step = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("freerun_ret[%0d]", n), 64'(retired), 64'(n / 4));
        end
        check("freerun_alu_f", 64'(alu_f), 64'h8000_0000);
        @(posedge clk);
        #1;
        check("freerun_fetch_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_retired", 64'(retired), 64'd0);
        check("midrst_addr", 64'(imem_addr), 64'd0);
        check("midrst_alu_f", 64'(alu_f), 64'd0);
        check("midrst_flags", 64'({fr_zf, fr_of, fr_cf, illegal, halted}), 64'd0);
        rst  = 1'b1;
        step = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rcpu_multicycle.md
Name: rcpu_multicycle

Overview:
- Parametrised multi-cycle R-type CPU core; successor to the single-step R-type CPU on the lab board.
- Fetches from an external synchronous instruction ROM, decodes MIPS R-format, executes on an internal ALU, writes back to an internal register file and updates a flag register.
- Sits between the debounced step-button pulse and the LED display mux.
- Adds over the previous core: parametrised widths, hardwired r0, signed SLT, SLLV shift, carry flag, illegal-op and halt detection, retired-instruction counter, explicit FSM.

Parameters:
- DW, 32, datapath and register width (power of 2, 8..64).
- RF_AW, 5, register file address width (2^RF_AW registers; instruction fields are truncated to RF_AW LSBs).
- IM_AW, 6, instruction ROM word-address width.
- RESET_PC, 0, byte PC value loaded on reset.

Ports:
- clk  in  1  core clock, all logic on its rising edge.
- rst  in  1  synchronous active-low reset.
- step  in  1  advance request: a single-cycle pulse, or held high for free-run.
- imem_addr  out  IM_AW  ROM word address (PC[IM_AW+1:2]).
- imem_data  in  32  ROM data, valid exactly 1 cycle after imem_addr.
- alu_f  out  DW  last written-back ALU result (registered).
- fr_zf  out  1  zero flag.
- fr_of  out  1  signed overflow flag.
- fr_cf  out  1  carry/borrow flag.
- illegal  out  1  sticky: an unsupported instruction was seen.
- halted  out  1  core stopped on the HALT word.
- busy  out  1  FSM not in IDLE.
- retired  out  16  count of instructions completed (WB cycles), wraps at 0xFFFF.

Behaviour:
- Reset (rst==0 at a posedge), taking priority over everything including mid-instruction:
  - FSM goes to IDLE and PC=RESET_PC.
  - All registers, alu_f, flags, illegal, halted and retired are cleared.
- FSM states are IDLE, FETCH, EXEC, WB.
  - IDLE: if step==1 and halted==0, go to FETCH; otherwise hold. step is sampled only in IDLE; pulses in other states are ignored.
  - FETCH: drive imem_addr from PC and go to EXEC.
  - EXEC: latch imem_data as IR, read rs/rt combinationally, compute the ALU result and flags into temporaries, go to WB.
  - WB: commit the writeback, flags, PC+4 and retired+1, then go to IDLE.
- Latency: 4 cycles per instruction from the cycle step is sampled; free-run retires 1 instruction per 4 cycles.
- PC wraps modulo 2^(IM_AW+2) bytes.
- Decode applies only when OP==6'b000000; funct selects the operation:
  - 100000 ADD: F=A+B; CF=carry out; OF=signed overflow.
  - 100010 SUB: F=A-B; CF=borrow; OF=signed overflow.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise.
  - 101010 SLT: F=1 if $signed(A)<$signed(B), else 0.
  - 000100 SLLV: F=B<<A[log2(DW)-1:0].
- For logical ops, SLT and SLLV, OF and CF are cleared to 0. ZF=(F==0) for all legal ops.
- Writeback:
  - A legal op writes F to rd unless rd==0. r0 always reads 0; a write to r0 is discarded, but alu_f and the flags still update.
- Illegal instruction (OP!=0 or unknown funct, excluding HALT):
  - No register write; alu_f and flags hold.
  - illegal is set (sticky until reset).
  - PC advances and retired increments.
- HALT word 32'hFFFF_FFFF:
  - In WB, halted is set, PC is not advanced and retired does not increment.
  - IDLE then ignores step until reset.
- Register reads are from state before this instruction's write; there are no hazards because the core is multi-cycle.
- busy=1 in FETCH, EXEC and WB.

Decomposition:
- Shared package rcpu_pkg:
  - FSM state enum (2-bit).
  - OP_RTYPE and the FUNCT_* codes.
  - ALU op enum (3-bit).
  - HALT_WORD constant.
- One sub-module, rcpu_alu:
  - Purely combinational; parametrised by DW.
  - Inputs a, b, op; outputs f, zf, of, cf.
- The register file is kept inline in this module.

Test Plan:
- Reset mid-instruction: hold step=1, drop rst low during EXEC → next cycle IDLE, PC=0, retired=0, all flags 0, alu_f=0.
- ADD overflow (registers preloaded via earlier instructions): r1=0x7FFFFFFF, r2=1, ADD r3,r1,r2 → alu_f=0x80000000, OF=1, CF=0, ZF=0; r3 reads back 0x80000000.
- SUB to zero plus r0 write: SUB r0,r4,r4 with r4=5 → alu_f=0, ZF=1, CF=0; a subsequent OR r5,r0,r0 gives alu_f=0, and r0 still reads 0.
- Signed SLT and SLLV: r1=0xFFFFFFFF, r2=1 → SLT gives F=1. Then r6=36, r7=3, SLLV r8,r7,r6 (B=r7, shift=r6) → F=3<<4=0x30, since shift=36 mod 32=4.
- Step timing: issue single-cycle step pulses 2 cycles apart → only the first is accepted (busy=1 during the second); retired increments once per 4 cycles under free-run.
- Illegal and HALT:
  - OP=6'b001000 → illegal=1, no register change, PC+4.
  - Then the HALT word → halted=1, PC frozen, further step pulses give busy=0 and retired unchanged.
